// File: rtl/robot_pkg.sv
// Shared types for the motor driver: FSM state, latched direction codes and
// the mapping from a direction to the sign applied to each wheel.
package robot_pkg;

  typedef enum logic [2:0] {
    ST_IDLE, ST_RAMP_UP, ST_RUN, ST_RAMP_DOWN, ST_DEADTIME, ST_FAULT
  } state_e;

  typedef enum logic [2:0] {
    DIR_STOP, DIR_FWD, DIR_BWD, DIR_LEFT, DIR_RIGHT
  } dir_e;

  typedef enum logic [1:0] {W_OFF, W_POS, W_NEG} wsign_e;

  typedef struct packed {
    wsign_e l;
    wsign_e r;
  } wheel_t;

  function automatic wheel_t wheel_map(input dir_e d);
    wheel_t w;
    w.l = W_OFF;
    w.r = W_OFF;
    case (d)
      DIR_FWD:   begin w.l = W_POS; w.r = W_POS; end
      DIR_BWD:   begin w.l = W_NEG; w.r = W_NEG; end
      DIR_LEFT:  begin w.l = W_NEG; w.r = W_POS; end
      DIR_RIGHT: begin w.l = W_POS; w.r = W_NEG; end
      default:   begin w.l = W_OFF; w.r = W_OFF; end
    endcase
    return w;
  endfunction

endpackage

// File: rtl/robot_pwm_gen.sv
// Free-running PWM counter with a combinational compare; the caller registers
// the result onto the pins.
module robot_pwm_gen #(
  parameter int PWM_BITS = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [PWM_BITS-1:0] duty,
  output logic                pwm
);

  logic [PWM_BITS-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) r_cnt <= '0;
    else        r_cnt <= r_cnt + PWM_BITS'(1);
  end

  assign pwm = (r_cnt < duty);

endmodule

// File: rtl/robot_motor_driver.sv
// H-bridge driver: turns one-hot motor commands into ramped PWM per wheel,
// with a dead-time gap on reversal and a fault state for malformed commands.
module robot_motor_driver
  import robot_pkg::*;
#(
  parameter int PWM_BITS  = 8,
  parameter int DUTY_MAX  = 200,
  parameter int RAMP_STEP = 8,
  parameter int RAMP_DIV  = 16,
  parameter int DEADTIME  = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                enable,
  input  logic                motor_fwd,
  input  logic                motor_bwd,
  input  logic                motor_left,
  input  logic                motor_right,
  input  logic                motor_stop,
  output logic                l_in1,
  output logic                l_in2,
  output logic                r_in1,
  output logic                r_in2,
  output logic [PWM_BITS-1:0] duty,
  output logic                busy,
  output logic                fault
);

  localparam int CW = $clog2((RAMP_DIV > DEADTIME) ? RAMP_DIV : DEADTIME) + 1;
  localparam logic [PWM_BITS-1:0] DMAX  = PWM_BITS'(DUTY_MAX);
  localparam logic [PWM_BITS-1:0] STEP  = PWM_BITS'(RAMP_STEP);
  localparam logic [CW-1:0]       T_END = CW'(RAMP_DIV - 1);
  localparam logic [CW-1:0]       D_END = CW'(DEADTIME - 1);

  state_e              r_state, w_state_n;
  dir_e                r_dir, w_dir_n, w_cmd_dir;
  logic [PWM_BITS-1:0] r_duty, w_duty_n, w_duty_up, w_duty_dn;
  logic [PWM_BITS:0]   w_sum;
  logic [CW-1:0]       r_presc, w_presc_n;
  logic                r_l_in1, r_l_in2, r_r_in1, r_r_in2;
  logic                w_valid, w_tick, w_pwm, w_active_n;
  wheel_t              w_map;

  robot_pwm_gen #(.PWM_BITS(PWM_BITS)) u_pwm (
    .clk  (clk),
    .rst_n(rst_n),
    .duty (r_duty),
    .pwm  (w_pwm)
  );

  assign w_valid = $onehot({motor_fwd, motor_bwd, motor_left, motor_right, motor_stop});
  assign w_tick  = (r_presc == T_END);
  assign w_sum   = {1'b0, r_duty} + {1'b0, STEP};
  assign w_duty_up = (w_sum >= {1'b0, DMAX}) ? DMAX : w_sum[PWM_BITS-1:0];
  assign w_duty_dn = (r_duty <= STEP) ? '0 : r_duty - STEP;

  always_comb begin
    w_cmd_dir = DIR_STOP;
    if      (motor_fwd)   w_cmd_dir = DIR_FWD;
    else if (motor_bwd)   w_cmd_dir = DIR_BWD;
    else if (motor_left)  w_cmd_dir = DIR_LEFT;
    else if (motor_right) w_cmd_dir = DIR_RIGHT;
  end

  // Prescaler doubles as the dead-time counter; it is cleared on every phase entry.
  always_comb begin
    w_state_n = r_state;
    w_duty_n  = r_duty;
    w_dir_n   = r_dir;
    w_presc_n = r_presc + CW'(1);
    if (!enable) begin
      w_state_n = ST_IDLE;
      w_duty_n  = '0;
      w_dir_n   = DIR_STOP;
    end else if (!w_valid && r_state != ST_FAULT) begin
      w_state_n = ST_FAULT;
      w_duty_n  = '0;
      w_dir_n   = DIR_STOP;
    end else begin
      case (r_state)
        ST_IDLE: if (w_cmd_dir != DIR_STOP) begin
          w_dir_n   = w_cmd_dir;
          w_state_n = ST_RAMP_UP;
          w_presc_n = '0;
        end
        ST_RAMP_UP: begin
          if (w_cmd_dir != r_dir) begin
            w_state_n = ST_RAMP_DOWN;
            w_presc_n = '0;
          end else if (w_tick) begin
            w_presc_n = '0;
            w_duty_n  = w_duty_up;
            if (w_duty_up == DMAX) w_state_n = ST_RUN;
          end
        end
        ST_RUN: if (w_cmd_dir != r_dir) begin
          w_state_n = ST_RAMP_DOWN;
          w_presc_n = '0;
        end
        ST_RAMP_DOWN: begin
          if (w_cmd_dir == r_dir) begin
            w_state_n = ST_RAMP_UP;
            w_presc_n = '0;
          end else if (w_tick) begin
            w_presc_n = '0;
            w_duty_n  = w_duty_dn;
            if (w_duty_dn == '0) w_state_n = ST_DEADTIME;
          end
        end
        ST_DEADTIME: if (r_presc == D_END) begin
          w_presc_n = '0;
          if (w_cmd_dir != DIR_STOP) begin
            w_dir_n   = w_cmd_dir;
            w_state_n = ST_RAMP_UP;
          end else begin
            w_dir_n   = DIR_STOP;
            w_state_n = ST_IDLE;
          end
        end
        ST_FAULT: if (w_valid && motor_stop) w_state_n = ST_IDLE;
        default: begin
          w_state_n = ST_IDLE;
          w_duty_n  = '0;
          w_dir_n   = DIR_STOP;
        end
      endcase
    end
  end

  // Legs are gated by the next state so safe-off lands on the very next edge.
  assign w_active_n = (w_state_n == ST_RAMP_UP) || (w_state_n == ST_RUN) ||
                      (w_state_n == ST_RAMP_DOWN);
  assign w_map = wheel_map(r_dir);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_duty  <= '0;
      r_dir   <= DIR_STOP;
      r_presc <= '0;
      r_l_in1 <= 1'b0;
      r_l_in2 <= 1'b0;
      r_r_in1 <= 1'b0;
      r_r_in2 <= 1'b0;
    end else begin
      r_state <= w_state_n;
      r_duty  <= w_duty_n;
      r_dir   <= w_dir_n;
      r_presc <= w_presc_n;
      r_l_in1 <= w_active_n & w_pwm & (w_map.l == W_POS);
      r_l_in2 <= w_active_n & w_pwm & (w_map.l == W_NEG);
      r_r_in1 <= w_active_n & w_pwm & (w_map.r == W_POS);
      r_r_in2 <= w_active_n & w_pwm & (w_map.r == W_NEG);
    end
  end

  assign l_in1 = r_l_in1;
  assign l_in2 = r_l_in2;
  assign r_in1 = r_r_in1;
  assign r_in2 = r_r_in2;
  assign duty  = r_duty;
  assign busy  = (r_state == ST_RAMP_UP) || (r_state == ST_RAMP_DOWN) ||
                 (r_state == ST_DEADTIME);
  assign fault = (r_state == ST_FAULT);

endmodule

// File: tb/tb_robot_motor_driver.sv
// Directed bench for robot_motor_driver: a per-cycle behavioural model plus
// hand-computed literal checkpoints along one long command scenario.
module tb_robot_motor_driver;

  logic       clk = 1'b0;
  logic       rst_n, enable;
  logic       motor_fwd, motor_bwd, motor_left, motor_right, motor_stop;
  logic       l_in1, l_in2, r_in1, r_in2;
  logic [7:0] duty;
  logic       busy, fault;

  int n_chk  = 0;
  int n_pass = 0;

  robot_motor_driver dut (
    .clk(clk), .rst_n(rst_n), .enable(enable),
    .motor_fwd(motor_fwd), .motor_bwd(motor_bwd), .motor_left(motor_left),
    .motor_right(motor_right), .motor_stop(motor_stop),
    .l_in1(l_in1), .l_in2(l_in2), .r_in1(r_in1), .r_in2(r_in2),
    .duty(duty), .busy(busy), .fault(fault)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  localparam int MI = 0, MU = 1, MR = 2, MD = 3, MT = 4, MF = 5;
  int  lsg [5] = '{0, 1, -1, -1, 1};  // stop, fwd, bwd, left, right
  int  rsg [5] = '{0, 1, -1, 1, -1};
  int  m_mode, m_duty, m_dir, m_ps, m_cnt;
  bit  m_l1, m_l2, m_r1, m_r2, m_valid = 0;

  always @(posedge clk) begin
    int n1, cd, nm, nd, ndir, nps;
    bit act, p, tick;
    if (!rst_n) begin
      m_mode = MI; m_duty = 0; m_dir = 0; m_ps = 0; m_cnt = 0;
      {m_l1, m_l2, m_r1, m_r2} = 4'b0;
      m_valid = 1;
    end else begin
      n1 = int'(motor_fwd) + int'(motor_bwd) + int'(motor_left) +
           int'(motor_right) + int'(motor_stop);
      cd = motor_fwd ? 1 : motor_bwd ? 2 : motor_left ? 3 : motor_right ? 4 : 0;
      nm = m_mode; nd = m_duty; ndir = m_dir; nps = m_ps + 1;
      tick = ((m_ps % 16) == 15);
      if (!enable) begin
        nm = MI; nd = 0; ndir = 0;
      end else if (n1 != 1 && m_mode != MF) begin
        nm = MF; nd = 0; ndir = 0;
      end else if (m_mode == MI) begin
        if (cd != 0) begin ndir = cd; nm = MU; nps = 0; end
      end else if (m_mode == MU) begin
        if (cd != m_dir) begin nm = MD; nps = 0; end
        else if (tick) begin
          nd = (m_duty + 8 > 200) ? 200 : m_duty + 8;
          if (nd == 200) nm = MR;
        end
      end else if (m_mode == MR) begin
        if (cd != m_dir) begin nm = MD; nps = 0; end
      end else if (m_mode == MD) begin
        if (cd == m_dir) begin nm = MU; nps = 0; end
        else if (tick) begin
          nd = (m_duty < 8) ? 0 : m_duty - 8;
          if (nd == 0) begin nm = MT; nps = 0; end
        end
      end else if (m_mode == MT) begin
        if (m_ps == 3) begin
          nps = 0;
          if (cd != 0) begin ndir = cd; nm = MU; end
          else begin ndir = 0; nm = MI; end
        end
      end else begin
        if (n1 == 1 && motor_stop) nm = MI;
      end
      act  = (nm == MU) || (nm == MR) || (nm == MD);
      p    = (m_cnt < m_duty);
      m_l1 = act && p && lsg[m_dir] == 1;
      m_l2 = act && p && lsg[m_dir] == -1;
      m_r1 = act && p && rsg[m_dir] == 1;
      m_r2 = act && p && rsg[m_dir] == -1;
      m_mode = nm; m_duty = nd; m_dir = ndir; m_ps = nps;
      m_cnt = (m_cnt + 1) % 256;
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      chk("cycle{duty,busy,fault,l1,l2,r1,r2}",
          int'({duty, busy, fault, l_in1, l_in2, r_in1, r_in2}),
          int'({8'(m_duty), (m_mode == MU || m_mode == MD || m_mode == MT),
                (m_mode == MF), m_l1, m_l2, m_r1, m_r2}));
      chk("leg_overlap", int'((l_in1 & l_in2) | (r_in1 & r_in2)), 0);
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_cmd(input logic [4:0] c);  // {fwd,bwd,left,right,stop}
    {motor_fwd, motor_bwd, motor_left, motor_right, motor_stop} = c;
  endtask

  task automatic count_hi(input int n, output int c1, output int c2,
                          output int c3, output int c4);
    c1 = 0; c2 = 0; c3 = 0; c4 = 0;
    repeat (n) begin
      @(negedge clk);
      c1 += int'(l_in1); c2 += int'(l_in2); c3 += int'(r_in1); c4 += int'(r_in2);
    end
  endtask

  localparam logic [4:0] C_FWD = 5'b10000, C_BWD = 5'b01000, C_LEFT = 5'b00100;
  localparam logic [4:0] C_RIGHT = 5'b00010, C_STOP = 5'b00001;

  initial begin
    int a, b, c, d;
    rst_n = 1'b0; enable = 1'b1; set_cmd(C_STOP);
    step(3);
    rst_n = 1'b1;
    step(4);
    chk("idle_duty", duty, 0);
    chk("idle_busy", busy, 0);
    chk("idle_fault", fault, 0);
    chk("idle_legs", int'({l_in1, l_in2, r_in1, r_in2}), 0);

    set_cmd(C_FWD);
    step(16); chk("up_before_tick", duty, 0); chk("up_busy", busy, 1);
    step(1);  chk("up_first_tick", duty, 8);
    step(383); chk("up_duty192", duty, 192);
    step(1);  chk("run_duty200", duty, 200); chk("run_busy", busy, 0);
    count_hi(256, a, b, c, d);
    chk("fwd_l1_hi", a, 200); chk("fwd_l2_hi", b, 0);
    chk("fwd_r1_hi", c, 200); chk("fwd_r2_hi", d, 0);

    set_cmd(C_BWD);
    step(209); chk("down_duty96", duty, 96); chk("down_busy", busy, 1);
    set_cmd(C_FWD);
    step(1);  chk("resume_duty96", duty, 96);
    step(16); chk("resume_duty104", duty, 104);
    step(192); chk("resume_run", duty, 200); chk("resume_busy", busy, 0);

    set_cmd(C_LEFT);
    count_hi(400, a, b, c, d);
    chk("left_rampdown_l1_pulses", int'(a > 0), 1);
    chk("left_rampdown_l2", b, 0);
    step(1); chk("dead_duty", duty, 0); chk("dead_busy", busy, 1);
    chk("dead_legs", int'({l_in1, l_in2, r_in1, r_in2}), 0);
    step(404); chk("left_run", duty, 200);
    count_hi(256, a, b, c, d);
    chk("left_l1_hi", a, 0); chk("left_l2_hi", b, 200);
    chk("left_r1_hi", c, 200); chk("left_r2_hi", d, 0);

    set_cmd(C_FWD | C_RIGHT);
    step(1); chk("multi_fault", fault, 1); chk("multi_duty", duty, 0);
    chk("multi_legs", int'({l_in1, l_in2, r_in1, r_in2}), 0);
    set_cmd(C_STOP);
    step(1); chk("fault_clear", fault, 0); chk("fault_clear_busy", busy, 0);
    set_cmd(5'b00000);
    step(1); chk("zero_fault", fault, 1);
    step(3); chk("zero_fault_hold", fault, 1);
    enable = 1'b0;
    step(1); chk("enable_clears_fault", fault, 0);
    enable = 1'b1; set_cmd(C_STOP);
    step(2);

    set_cmd(C_FWD);
    step(129); chk("en_duty64", duty, 64);
    enable = 1'b0;
    step(1); chk("en_off_duty", duty, 0); chk("en_off_busy", busy, 0);
    chk("en_off_legs", int'({l_in1, l_in2, r_in1, r_in2}), 0);
    enable = 1'b1;
    step(420); chk("rerun", duty, 200);
    rst_n = 1'b0;
    step(1); chk("rst_duty", duty, 0); chk("rst_busy", busy, 0);
    chk("rst_fault", fault, 0);
    chk("rst_legs", int'({l_in1, l_in2, r_in1, r_in2}), 0);
    rst_n = 1'b1;

    step(410); chk("post_rst_run", duty, 200);
    set_cmd(C_STOP);
    step(420); chk("stop_idle_duty", duty, 0); chk("stop_idle_busy", busy, 0);
    step(5);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
